// File: rtl/sync_counter_pkg.sv
// Shared types and constants for the counter run controller and its datapath.
package sync_counter_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_active(state_t s);
        return (s == RUN) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/count_core.sv
// WIDTH-bit count register: async active-low clear, synchronous zero-load and increment.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load_zero,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (load_zero) begin
            q <= '0;
        end else if (inc) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sync_counter_ctrl.sv
// Run controller for the synchronous counter: start/pause/stop sequencing,
// programmable terminal value, one-shot or periodic mode, done/err pulses.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped, Q=0; terminal value writable
// RUN   | counting toward term; wraps (periodic) or finishes (one-shot)
// PAUSE | count frozen; start resumes, stop aborts to IDLE
// DONE  | one-shot finished, Q holds term until start or stop
module sync_counter_ctrl
    import sync_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_term,
    output logic [WIDTH-1:0] Q,
    output logic             c_enable,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] term_nxt;
    logic             mode_q;
    logic             mode_nxt;
    logic             load_zero;
    logic             inc;
    logic             done_nxt;
    logic             err_nxt;
    logic             term_hit;

    assign term_hit = (Q == term_q);

    count_core #(
        .WIDTH (WIDTH)
    ) u_count_core (
        .clock     (clock),
        .clear     (clear),
        .load_zero (load_zero),
        .inc       (inc),
        .q         (Q)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            term_q   <= '1;
            mode_q   <= MODE_ONESHOT;
            c_enable <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            term_q   <= term_nxt;
            mode_q   <= mode_nxt;
            c_enable <= (state_nxt == RUN);
            busy     <= is_active(state_nxt);
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        term_nxt  = term_q;
        mode_nxt  = mode_q;
        load_zero = 1'b0;
        inc       = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        // The terminal value may only change while stopped, so Q never passes it.
        if (cfg_we) begin
            if (state == IDLE) begin
                term_nxt = cfg_term;
            end else begin
                err_nxt = 1'b1;
            end
        end

        // stop outranks start everywhere, and outranks the terminal event in RUN.
        unique case (state)
            IDLE: begin
                if (!stop && start) begin
                    if (term_q == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        load_zero = 1'b1;
                        mode_nxt  = mode;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = PAUSE;
                end else if (term_hit) begin
                    done_nxt = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        load_zero = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    inc = 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_nxt = IDLE;
                    load_zero = 1'b1;
                end else if (start) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                if (stop) begin
                    state_nxt = IDLE;
                    load_zero = 1'b1;
                end else if (start) begin
                    state_nxt = RUN;
                    load_zero = 1'b1;
                    mode_nxt  = mode;
                end
            end
            default: begin
                state_nxt = IDLE;
                load_zero = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// Self-checking bench for sync_counter_ctrl: vector table plus scoreboarded sequences.
module tb_sync_counter_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        logic [3:0] q;
        logic       cen;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic       s;
        logic       p;
        logic       m;
        logic       we;
        logic [3:0] t;
        exp_t       e;
    } vec_t;

    logic       clock = 1'b0;
    logic       clear;
    logic       start;
    logic       stop;
    logic       mode;
    logic       cfg_we;
    logic [3:0] cfg_term;
    logic [3:0] Q;
    logic       c_enable;
    logic       busy;
    logic       done;
    logic       err;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic obs_done;

    int         m_st;
    logic [3:0] m_q;
    logic [3:0] m_term;
    logic       m_mode;
    logic       m_done;
    logic       m_err;

    sync_counter_ctrl #(.WIDTH(4)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .cfg_we   (cfg_we),
        .cfg_term (cfg_term),
        .Q        (Q),
        .c_enable (c_enable),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_st = M_IDLE; m_q = 4'd0; m_term = 4'hF; m_mode = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endtask

    // Behavioural reference: computes the state after one rising edge.
    task automatic model_step(input logic s, input logic p, input logic m, input logic we, input logic [3:0] t);
        logic [3:0] old_term;
        int         old_st;
        old_term = m_term;
        old_st   = m_st;
        m_done   = 1'b0;
        m_err    = 1'b0;
        if (we) begin
            if (old_st == M_IDLE) m_term = t;
            else m_err = 1'b1;
        end
        case (old_st)
            M_IDLE: if (!p && s) begin
                if (old_term == 4'd0) m_err = 1'b1;
                else begin m_st = M_RUN; m_q = 4'd0; m_mode = m; end
            end
            M_RUN: begin
                if (p) m_st = M_PAUSE;
                else if (m_q == old_term) begin
                    m_done = 1'b1;
                    if (m_mode) m_q = 4'd0;
                    else m_st = M_DONE;
                end else m_q = m_q + 4'd1;
            end
            M_PAUSE: begin
                if (p) begin m_st = M_IDLE; m_q = 4'd0; end
                else if (s) m_st = M_RUN;
            end
            default: begin
                if (p) begin m_st = M_IDLE; m_q = 4'd0; end
                else if (s) begin m_st = M_RUN; m_q = 4'd0; m_mode = m; end
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.q    = m_q;
        e.cen  = (m_st == M_RUN);
        e.busy = (m_st == M_RUN) || (m_st == M_PAUSE);
        e.done = m_done;
        e.err  = m_err;
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t a;
        exp_t e;
        a.q = Q; a.cen = c_enable; a.busy = busy; a.done = done; a.err = err;
        obs_done = done;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued, got q=%0d cen=%b busy=%b done=%b err=%b",
                     tag, a.q, a.cen, a.busy, a.done, a.err);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got q=%0d cen=%b busy=%b done=%b err=%b, want q=%0d cen=%b busy=%b done=%b err=%b",
                         tag, a.q, a.cen, a.busy, a.done, a.err, e.q, e.cen, e.busy, e.done, e.err);
            end
        end
    endtask

    task automatic apply(input logic s, input logic p, input logic m, input logic we, input logic [3:0] t,
                         input logic use_exp, input exp_t ex, input string tag);
        start = s; stop = p; mode = m; cfg_we = we; cfg_term = t;
        model_step(s, p, m, we, t);
        sb.push_back(use_exp ? ex : model_out());
        @(posedge clock);
        #1;
        check(tag);
        start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic step(input logic s, input logic p, input logic m, input logic we, input logic [3:0] t,
                        input string tag);
        apply(s, p, m, we, t, 1'b0, '0, tag);
    endtask

    task automatic cmp_int(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Idles until done is seen; returns edges since the last start edge, or -1 on timeout.
    task automatic wait_done(input int base, input string tag, output int t_done);
        int cyc;
        cyc    = base;
        t_done = -1;
        for (int i = 0; i < 40 && t_done < 0; i++) begin
            step(0, 0, 0, 0, 4'd0, tag);
            cyc++;
            if (obs_done) t_done = cyc;
        end
    endtask

    function automatic vec_t mk(input logic s, input logic p, input logic m, input logic we, input logic [3:0] t,
                                input logic [3:0] q, input logic cen, input logic bsy, input logic dn, input logic er);
        vec_t v;
        v.s = s; v.p = p; v.m = m; v.we = we; v.t = t;
        v.e.q = q; v.e.cen = cen; v.e.busy = bsy; v.e.done = dn; v.e.err = er;
        return v;
    endfunction

    initial begin
        int t_done;
        int n_done;

        //             s  p  m  we t       q  cen bsy dn er
        vecs.push_back(mk(0, 0, 0, 1, 4'd5, 4'd0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd3, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd4, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd5, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd5, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'd2, 4'd0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'd7, 4'd1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0));

        clear = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; cfg_we = 1'b0; cfg_term = 4'd0;
        obs_done = 1'b0;
        model_reset();
        #12;
        n_tests++;
        if ({Q, c_enable, busy, done, err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: got q=%0d cen=%b busy=%b done=%b err=%b, want all 0", Q, c_enable, busy, done, err);
        end
        clear = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].s, vecs[i].p, vecs[i].m, vecs[i].we, vecs[i].t, 1'b1, vecs[i].e,
                  $sformatf("vec[%0d]", i));
        end

        // Periodic, term=3: five full periods then stop, stop.
        step(0, 0, 0, 1, 4'd3, "per_cfg");
        step(1, 0, 1, 0, 4'd0, "per_start");
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 4'd0, $sformatf("per_run[%0d]", i));
            if (obs_done) n_done++;
        end
        cmp_int("per_done_count", n_done, 5);
        step(0, 1, 0, 0, 4'd0, "per_stop1");
        step(0, 1, 0, 0, 4'd0, "per_stop2");

        // Unpaused reference run, term=9.
        step(0, 0, 0, 1, 4'd9, "pr_cfg");
        step(1, 0, 0, 0, 4'd0, "pr_start_ref");
        wait_done(0, "pr_ref_run", t_done);
        cmp_int("pr_ref_done_latency", t_done, 10);
        step(0, 1, 0, 0, 4'd0, "pr_ref_abort");

        // Paused run: stop at Q=4, hold three cycles, resume; done 5 edges later.
        step(1, 0, 0, 0, 4'd0, "pr_start");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'd0, $sformatf("pr_count[%0d]", i));
        cmp_int("pr_q_before_stop", int'(Q), 4);
        step(0, 1, 0, 0, 4'd0, "pr_stop");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'd0, $sformatf("pr_hold[%0d]", i));
        step(1, 0, 0, 0, 4'd0, "pr_resume");
        wait_done(9, "pr_run", t_done);
        cmp_int("pr_paused_done_latency", t_done, 15);
        step(0, 1, 0, 0, 4'd0, "pr_abort");

        // Stop coinciding with the terminal count.
        step(0, 0, 0, 1, 4'd3, "ts_cfg");
        step(1, 0, 0, 0, 4'd0, "ts_start");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'd0, $sformatf("ts_count[%0d]", i));
        step(0, 1, 0, 0, 4'd0, "ts_stop_at_term");
        step(0, 0, 0, 0, 4'd0, "ts_hold");
        step(1, 0, 0, 0, 4'd0, "ts_resume");
        step(0, 0, 0, 0, 4'd0, "ts_terminal");
        cmp_int("ts_done_after_resume", int'(obs_done), 1);
        step(0, 1, 0, 0, 4'd0, "ts_abort");

        // Asynchronous clear mid-run, then term must be back at 15.
        step(0, 0, 0, 1, 4'd15, "rst_cfg");
        step(1, 0, 0, 0, 4'd0, "rst_start");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 4'd0, $sformatf("rst_count[%0d]", i));
        #2;
        clear = 1'b0;
        #1;
        n_tests++;
        if ({Q, c_enable, busy, done, err} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_clear: got q=%0d cen=%b busy=%b done=%b err=%b, want all 0",
                     Q, c_enable, busy, done, err);
        end
        model_reset();
        #3;
        clear = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'd0, $sformatf("rst_idle[%0d]", i));
        step(1, 0, 0, 0, 4'd0, "rst_restart");
        wait_done(0, "rst_run", t_done);
        cmp_int("rst_term_all_ones_latency", t_done, 16);

        cmp_int("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
